imem_loader: RTL and testbench

//   Writer side of the instruction memory: receives a program image as a byte stream

---
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: LEN, LEN data bytes, CSUM frame streamed into imem, CPU held until a good image lands.
// Latency: one cycle from an accepted data byte to its mem_we pulse; status flags update on the accepting edge.
// Backpressure: s_ready is high only while a frame is open (LEN/DATA/CSUM); idle/done/error states refuse bytes.
module imem_loader #(
   parameter int DEPTH   = 36,
   parameter int TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_hold,
   output logic       busy,
   output logic       load_done,
   output logic       load_err,
   output logic [1:0] err_code,
   output logic [7:0] count
);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

   localparam int            TW        = $clog2(TIMEOUT + 1);
   localparam logic [7:0]    DEPTH_B   = 8'(DEPTH);
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [7:0]    len, idx, sum, sum_nxt;
   logic [TW-1:0] idle_cnt;
   logic          xfer, len_bad, last_byte, timeout_hit;

   assign xfer        = s_valid & s_ready;
   assign sum_nxt     = sum + s_data;
   assign len_bad     = (s_data == 8'd0) || (s_data > DEPTH_B);
   assign last_byte   = (idx == len - 8'd1);
   assign timeout_hit = busy & ~xfer & (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LEN;
         S_LEN: begin
            if (xfer)             state_nxt = len_bad ? S_ERR : S_DATA;
            else if (timeout_hit) state_nxt = S_ERR;
         end
         S_DATA: begin
            if (xfer && last_byte) state_nxt = S_CSUM;
            else if (timeout_hit)  state_nxt = S_ERR;
         end
         S_CSUM: begin
            if (xfer)             state_nxt = (sum_nxt == 8'd0) ? S_DONE : S_ERR;
            else if (timeout_hit) state_nxt = S_ERR;
         end
         S_DONE, S_ERR: if (start) state_nxt = S_LEN;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
      s_ready  = busy;
      cpu_hold = (state != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_we    <= 1'b0;
         mem_addr  <= 8'd0;
         mem_wdata <= 8'd0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         err_code  <= 2'b00;
         count     <= 8'd0;
         len       <= 8'd0;
         idx       <= 8'd0;
         sum       <= 8'd0;
         idle_cnt  <= '0;
      end else begin
         mem_we <= 1'b0;

         // idle counter restarts on every accepted byte and whenever a session opens
         if (busy)                idle_cnt <= xfer ? '0 : idle_cnt + TW'(1);
         else if (start)          idle_cnt <= '0;

         case (state)
            S_LEN: if (xfer) begin
               len <= s_data;
               idx <= 8'd0;
               sum <= 8'd0;
               if (len_bad) begin
                  load_err <= 1'b1;
                  err_code <= 2'b01;
               end
            end
            S_DATA: if (xfer) begin
               mem_we    <= 1'b1;
               mem_addr  <= idx;
               mem_wdata <= s_data;
               count     <= count + 8'd1;
               sum       <= sum_nxt;
               if (!last_byte) idx <= idx + 8'd1;
            end
            S_CSUM: if (xfer) begin
               if (sum_nxt == 8'd0) load_done <= 1'b1;
               else begin
                  load_err <= 1'b1;
                  err_code <= 2'b10;
               end
            end
            S_DONE, S_ERR: if (start) begin
               load_done <= 1'b0;
               load_err  <= 1'b0;
               err_code  <= 2'b00;
               count     <= 8'd0;
            end
            default: ;
         endcase

         if (timeout_hit) begin
            load_err <= 1'b1;
            err_code <= 2'b11;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus randomized frames checked against a frame-level model.
module tb_imem_loader;
   localparam int DEPTH   = 36;
   localparam int TIMEOUT = 1024;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'd0;
   logic       s_ready, mem_we, cpu_hold, busy, load_done, load_err;
   logic [7:0] mem_addr, mem_wdata, count;
   logic [1:0] err_code;

   int n_chk = 0;
   int n_fail = 0;
   logic [15:0] wq[$];

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_err(load_err),
      .err_code(err_code), .count(count)
   );

   // every memory write as {addr, data}, sampled mid-cycle
   always @(negedge clk) if (mem_we) wq.push_back({mem_addr, mem_wdata});

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
      s_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
         s_data = 8'($urandom);
         start  = poke_start && (i == 0);
         step();
      end
      start   = 1'b0;
      s_valid = 1'b1;
      s_data  = b;
      for (int w = 0; w < 50 && !s_ready; w++) step();
      chk("s_ready_before_xfer", s_ready, 1);
      step();
      s_valid = 1'b0;
      s_data  = 8'($urandom);
   endtask

   // Frame-level model: expected writes are (i, dat[i]); outcome from LEN range and byte-sum rule.
   task automatic run_frame(input logic [7:0] len, input logic [7:0] dat[$],
                            input logic [7:0] csum, input int maxgap, input bit pokes);
      int  total;
      bit  bad, good;
      total = 0;
      wq.delete();
      pulse_start();
      chk("start_busy", busy, 1);
      chk("start_hold", cpu_hold, 1);
      chk("start_done_clr", load_done, 0);
      chk("start_err_clr", load_err, 0);
      chk("start_code_clr", err_code, 0);
      chk("start_count_clr", count, 0);
      bad = (len == 0) || (int'(len) > DEPTH);
      send_byte(len, $urandom_range(maxgap, 0), 1'b0);
      if (bad) begin
         chk("badlen_err", load_err, 1);
         chk("badlen_code", err_code, 2'b01);
         chk("badlen_busy", busy, 0);
         chk("badlen_hold", cpu_hold, 1);
         repeat (3) step();
         chk("badlen_writes", wq.size(), 0);
         chk("badlen_ready", s_ready, 0);
         return;
      end
      for (int i = 0; i < int'(len); i++) begin
         bit p;
         p = pokes && ($urandom_range(3, 0) == 0);
         send_byte(dat[i], p ? 1 : $urandom_range(maxgap, 0), p);
         total += int'(dat[i]);
      end
      send_byte(csum, $urandom_range(maxgap, 0), 1'b0);
      good = ((total + int'(csum)) % 256) == 0;
      chk("end_done", load_done, good);
      chk("end_err", load_err, !good);
      chk("end_code", err_code, good ? 2'b00 : 2'b10);
      chk("end_hold", cpu_hold, !good);
      chk("end_busy", busy, 0);
      chk("end_count", count, len);
      step();
      chk("nwrites", wq.size(), len);
      for (int i = 0; i < wq.size() && i < int'(len); i++) begin
         chk("waddr", wq[i][15:8], i);
         chk("wdata", wq[i][7:0], dat[i]);
      end
      chk("addr_hold", mem_addr, len - 8'd1);
      chk("wdata_hold", mem_wdata, dat[len-1]);
   endtask

   function automatic logic [7:0] good_csum(input logic [7:0] dat[$]);
      int t;
      t = 0;
      foreach (dat[i]) t += int'(dat[i]);
      return 8'((256 - (t % 256)) % 256);
   endfunction

   initial begin
      logic [7:0] d[$];
      logic [7:0] len, cs;

      // reset state
      repeat (3) step();
      chk("rst_ready", s_ready, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", load_done, 0);
      chk("rst_err", load_err, 0);
      chk("rst_code", err_code, 0);
      chk("rst_count", count, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_hold", cpu_hold, 1);
      reset = 1'b1;

      // idle never accepts bytes
      s_valid = 1'b1; s_data = 8'hA5;
      repeat (3) step();
      chk("idle_ready", s_ready, 0);
      s_valid = 1'b0;
      step();
      chk("idle_writes", wq.size(), 0);

      // good and bad-checksum versions of the reference frame
      d = '{8'h23, 8'h61, 8'h02};
      run_frame(8'd3, d, 8'h7A, 0, 1'b0);
      run_frame(8'd3, d, 8'h00, 0, 1'b0);

      // LEN boundaries
      d.delete();
      run_frame(8'd0, d, 8'h00, 0, 1'b0);
      run_frame(8'h25, d, 8'h00, 0, 1'b0);
      d = '{8'h5C};
      run_frame(8'd1, d, good_csum(d), 1, 1'b0);
      d.delete();
      for (int i = 0; i < DEPTH; i++) d.push_back(8'($urandom));
      run_frame(8'(DEPTH), d, good_csum(d), 1, 1'b0);

      // timeout after one data byte
      wq.delete();
      pulse_start();
      send_byte(8'd2, 0, 1'b0);
      send_byte(8'h5A, 0, 1'b0);
      repeat (TIMEOUT - 1) step();
      chk("to_still_busy", busy, 1);
      chk("to_no_err_yet", load_err, 0);
      step();
      chk("to_err", load_err, 1);
      chk("to_code", err_code, 2'b11);
      chk("to_count", count, 1);
      chk("to_busy", busy, 0);
      chk("to_hold", cpu_hold, 1);
      chk("to_writes", wq.size(), 1);

      // reset in the middle of DATA
      wq.delete();
      pulse_start();
      send_byte(8'd4, 0, 1'b0);
      send_byte(8'h11, 0, 1'b0);
      send_byte(8'h22, 0, 1'b0);
      s_valid = 1'b1; s_data = 8'h33;
      reset = 1'b0;
      step();
      chk("mrst_busy", busy, 0);
      chk("mrst_count", count, 0);
      chk("mrst_hold", cpu_hold, 1);
      chk("mrst_we", mem_we, 0);
      chk("mrst_ready", s_ready, 0);
      reset = 1'b1;
      repeat (5) step();
      s_valid = 1'b0;
      chk("mrst_writes", wq.size(), 2);
      if (wq.size() >= 2) begin
         chk("mrst_w0", wq[0], 16'h0011);
         chk("mrst_w1", wq[1], 16'h0122);
      end
      d = '{8'h23, 8'h61, 8'h02};
      run_frame(8'd3, d, 8'h7A, 0, 1'b0);

      // gapped valid with start pulses during DATA
      d.delete();
      for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
      run_frame(8'd8, d, good_csum(d), 3, 1'b1);

      // randomized frames
      for (int f = 0; f < 25; f++) begin
         int sel;
         sel = $urandom_range(7, 0);
         if (sel == 0)      len = 8'd0;
         else if (sel == 1) len = 8'($urandom_range(DEPTH + 4, DEPTH + 1));
         else               len = 8'($urandom_range(DEPTH, 1));
         d.delete();
         for (int i = 0; i < int'(len); i++) d.push_back(8'($urandom));
         cs = good_csum(d);
         if ($urandom_range(3, 0) == 0) cs = cs + 8'($urandom_range(255, 1));
         run_frame(len, d, cs, 2, $urandom_range(1, 0) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
